// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared source/tag types and payload widths for the memory port arbiter
package mem_arb_pkg;
  localparam int REQ_W = 32;
  localparam int RESP_W = 32;
  typedef enum logic {SRC_IF, SRC_D} arb_src_t;
  typedef struct packed {
    arb_src_t src;
    logic stale;
  } arb_tag_t;
endpackage

// File: rtl/mem_arb_tag_fifo.sv
// mem_arb_tag_fifo: in-order tag FIFO of in-flight requests with per-source stale marking
module mem_arb_tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  arb_tag_t push_tag,
  input  logic pop,
  input  logic flush,
  input  arb_src_t flush_src,
  output arb_tag_t head,
  output logic full,
  output logic empty,
  output logic [CW-1:0] count
);
  arb_tag_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head = '{src: mem[rd].src, stale: mem[rd].stale || (flush && mem[rd].src == flush_src)};
  // pointers wrap at DEPTH; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= nxt(wr);
      if (pop) rd <= nxt(rd);
      count <= count + CW'(push) - CW'(pop);
    end
  // entry storage; a flush marks every entry of the flushed source stale in place
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else
      for (int i = 0; i < DEPTH; i++)
        if (push && wr == PW'(i)) mem[i] <= push_tag;
        else if (flush && mem[i].src == flush_src) mem[i].stale <= 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port by fetch and data stages (optional perf counters: MEM_ARB_PERF_CNT_EN)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req_valid,
  output logic if_req_ready,
  input  logic [REQ_W-1:0] if_req_data,
  output logic if_resp_valid,
  input  logic if_resp_ready,
  output logic [RESP_W-1:0] if_resp_data,
  input  logic d_req_valid,
  output logic d_req_ready,
  input  logic [REQ_W-1:0] d_req_data,
  output logic d_resp_valid,
  input  logic d_resp_ready,
  output logic [RESP_W-1:0] d_resp_data,
  input  logic if_flush,
  output logic mem_req_valid,
  input  logic mem_req_ready,
  output logic [REQ_W-1:0] mem_req_data,
  input  logic mem_resp_valid,
  output logic mem_resp_ready,
  input  logic [RESP_W-1:0] mem_resp_data
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_if_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_dropped
`endif
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  arb_src_t grant, lock_src, last_grant;
  arb_tag_t head;
  logic lock, if_elig, d_elig, can_issue, issue, pop, full, empty, hd_if, hd_d, hd_stale;
  logic [CW-1:0] count;
  // round-robin grant that holds while the port stalls; a flushed fetch is never eligible
  always_comb begin
    if_elig = rst_n && if_req_valid && !if_flush;
    d_elig = rst_n && d_req_valid;
    grant = lock ? lock_src : (if_elig != d_elig) ? (if_elig ? SRC_IF : SRC_D) : (last_grant == SRC_IF ? SRC_D : SRC_IF);
    can_issue = rst_n && !full;
    mem_req_valid = (grant == SRC_IF ? if_elig : d_elig) && can_issue;
    mem_req_data = grant == SRC_IF ? if_req_data : d_req_data;
    if_req_ready = grant == SRC_IF && !if_flush && mem_req_ready && can_issue;
    d_req_ready = grant == SRC_D && mem_req_ready && can_issue;
    issue = mem_req_valid && mem_req_ready;
  end
  // steer the in-order response to the FIFO head's issuer, silently draining stale fetches
  always_comb begin
    hd_if = !empty && head.src == SRC_IF && !head.stale;
    hd_d = !empty && head.src == SRC_D;
    hd_stale = !empty && head.stale;
    if_resp_valid = hd_if && mem_resp_valid;
    d_resp_valid = hd_d && mem_resp_valid;
    mem_resp_ready = hd_if ? if_resp_ready : hd_d ? d_resp_ready : hd_stale;
    pop = mem_resp_valid && mem_resp_ready;
  end
  assign if_resp_data = mem_resp_data;
  assign d_resp_data = mem_resp_data;
  // lock remembers a stalled grant; last_grant records the most recent issuer for fairness
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lock <= 1'b0;
      lock_src <= SRC_IF;
      last_grant <= SRC_D;
    end else begin
      if (mem_req_valid) begin
        lock <= !mem_req_ready;
        lock_src <= grant;
      end else if (lock && lock_src == SRC_IF && if_flush) lock <= 1'b0;
      if (issue) last_grant <= grant;
    end
  mem_arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tags (
    .clk(clk),
    .rst_n(rst_n),
    .push(issue),
    .push_tag('{src: grant, stale: 1'b0}),
    .pop(pop),
    .flush(if_flush),
    .flush_src(SRC_IF),
    .head(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // a response with nothing in flight means the memory side broke ordering
  assert property (@(posedge clk) disable iff (!rst_n) !(mem_resp_valid && empty));
  assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(MAX_OUTSTANDING));
`ifdef MEM_ARB_PERF_CNT_EN
  // free-running event counters for issues per source and dropped stale responses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_if_grants <= '0;
      perf_d_grants <= '0;
      perf_dropped <= '0;
    end else begin
      if (issue && grant == SRC_IF) perf_if_grants <= perf_if_grants + 32'd1;
      if (issue && grant == SRC_D) perf_d_grants <= perf_d_grants + 32'd1;
      if (pop && hd_stale) perf_dropped <= perf_dropped + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench against a queue-based reference of the arbiter
module tb_mem_port_arbiter;
  localparam int MO = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_req_valid = 0, if_req_ready, if_resp_valid, if_resp_ready = 0;
  logic d_req_valid = 0, d_req_ready, d_resp_valid, d_resp_ready = 0;
  logic if_flush = 0, mem_req_valid, mem_req_ready = 0, mem_resp_valid = 0, mem_resp_ready;
  logic [31:0] if_req_data = 0, if_resp_data, d_req_data = 0, d_resp_data, mem_req_data, mem_resp_data = 0;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_grants, perf_d_grants, perf_dropped;
`endif
  mem_port_arbiter #(.MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_data(if_req_data),
    .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready), .if_resp_data(if_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_data(d_req_data),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready), .d_resp_data(d_resp_data),
    .if_flush(if_flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants), .perf_dropped(perf_dropped)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {bit is_d; bit stale; logic [31:0] addr;} ent_t;
  typedef struct {bit is_d; logic [31:0] data;} mexp_t;
  ent_t outq[$];
  mexp_t exp_mem[$];
  logic [31:0] exp_if[$], exp_d[$];
  bit exp_mrdy[$];
  int checks = 0, failures = 0, ni = 0, nd = 0, ndrop = 0;
  bit last_d = 1, lock = 0, lock_d = 0, rv_hold = 0;
  bit iv = 0, dv = 0, fl = 0, mrdy = 0, rv_en = 0, irdy = 0, drdy = 0;
  logic [31:0] ia = 0, da = 0;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  // one bus cycle: drive pending stimulus, predict the arbiter's behaviour from its rules
  task automatic step();
    bit ie, de, gd, ge, mv, iss, rdy;
    ent_t h;
    @(negedge clk);
    if_req_valid = iv; if_req_data = ia; d_req_valid = dv; d_req_data = da;
    if_flush = fl; mem_req_ready = mrdy; if_resp_ready = irdy; d_resp_ready = drdy;
    mem_resp_valid = outq.size() > 0 && (rv_hold || rv_en);
    mem_resp_data = outq.size() > 0 ? ~outq[0].addr : 32'h0;
    if (fl) for (int i = 0; i < outq.size(); i++) if (!outq[i].is_d) outq[i].stale = 1'b1;
    ie = iv && !fl;
    de = dv;
    gd = lock ? lock_d : (ie && !de) ? 1'b0 : (de && !ie) ? 1'b1 : !last_d;
    ge = gd ? de : ie;
    mv = ge && outq.size() < MO;
    iss = mv && mrdy;
    if (iss) exp_mem.push_back('{gd, gd ? da : ia});
    rdy = 0;
    if (mem_resp_valid) begin
      h = outq[0];
      rdy = h.stale ? 1'b1 : h.is_d ? drdy : irdy;
      exp_mrdy.push_back(rdy);
      if (rdy) begin
        if (h.stale) ndrop++;
        else if (h.is_d) exp_d.push_back(~h.addr);
        else exp_if.push_back(~h.addr);
        void'(outq.pop_front());
      end
    end
    rv_hold = mem_resp_valid && !rdy;
    if (mv) begin lock = !mrdy; lock_d = gd; end
    else if (lock && !lock_d && fl) lock = 0;
    if (iss) begin
      outq.push_back('{gd, 1'b0, gd ? da : ia});
      last_d = gd;
      if (gd) begin dv = 0; nd++; end else begin iv = 0; ni++; end
    end
    if (fl) iv = 0;
  endtask
  // monitor: pops the scoreboard whenever the DUT completes a transfer
  always @(negedge clk) begin
    mexp_t e;
    #3;
    if (rst_n) begin
      if (mem_req_valid && mem_req_ready) begin
        if (exp_mem.size() == 0) chk("mem_req_unexpected", 1, 0);
        else begin
          e = exp_mem.pop_front();
          chk("mem_req_data", mem_req_data, e.data);
          chk("if_handshake", {31'b0, if_req_valid && if_req_ready}, {31'b0, !e.is_d});
          chk("d_handshake", {31'b0, d_req_valid && d_req_ready}, {31'b0, e.is_d});
        end
      end
      if (if_resp_valid && if_resp_ready) begin
        if (exp_if.size() == 0) chk("if_resp_unexpected", 1, 0);
        else chk("if_resp_data", if_resp_data, exp_if.pop_front());
      end
      if (d_resp_valid && d_resp_ready) begin
        if (exp_d.size() == 0) chk("d_resp_unexpected", 1, 0);
        else chk("d_resp_data", d_resp_data, exp_d.pop_front());
      end
      if (mem_resp_valid && exp_mrdy.size() > 0) chk("mem_resp_ready", {31'b0, mem_resp_ready}, {31'b0, exp_mrdy.pop_front()});
      if (exp_mem.size() > 0) begin chk("mem_req_missing", 0, 1); exp_mem.delete(); end
      if (exp_if.size() > 0) begin chk("if_resp_missing", 0, 1); exp_if.delete(); end
      if (exp_d.size() > 0) begin chk("d_resp_missing", 0, 1); exp_d.delete(); end
    end
  end
  task automatic rand_inputs();
    if (!iv && $urandom_range(9) < 6) begin iv = 1; ia = $urandom & 32'h0000_FFFC; end
    if (!dv && $urandom_range(9) < 5) begin dv = 1; da = 32'h1000_0000 | ($urandom & 32'hFFFC); end
    fl = $urandom_range(15) == 0;
    mrdy = $urandom_range(9) < 7;
    rv_en = $urandom_range(9) < 6;
    irdy = $urandom_range(9) < 8;
    drdy = $urandom_range(9) < 7;
  endtask
  initial begin
    if_req_valid = 1; d_req_valid = 1; mem_resp_valid = 1;
    #12;
    chk("reset_mem_req_valid", {31'b0, mem_req_valid}, 0);
    chk("reset_if_resp_valid", {31'b0, if_resp_valid}, 0);
    chk("reset_d_resp_valid", {31'b0, d_resp_valid}, 0);
    chk("reset_if_req_ready", {31'b0, if_req_ready}, 0);
    if_req_valid = 0; d_req_valid = 0; mem_resp_valid = 0;
    @(negedge clk) rst_n = 1;
    iv = 1; ia = 32'h80; dv = 1; da = 32'h2000; mrdy = 1;
    for (int i = 0; i < 4; i++) step();
    iv = 1; ia = 32'h84; rv_en = 1; irdy = 1; drdy = 0;
    for (int i = 0; i < 4; i++) step();
    drdy = 1;
    for (int i = 0; i < 4; i++) step();
    dv = 1; da = 32'h1000; mrdy = 0; rv_en = 1;
    step();
    iv = 1; ia = 32'h100;
    for (int i = 0; i < 3; i++) step();
    mrdy = 1;
    for (int i = 0; i < 6; i++) step();
    iv = 1; ia = 32'h80; rv_en = 0;
    step();
    fl = 1; rv_en = 1;
    step();
    fl = 0; iv = 1; ia = 32'h180;
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 2500; i++) begin rand_inputs(); step(); end
    fl = 0; rv_en = 0; mrdy = 1;
    for (int i = 0; i < 20 && outq.size() < MO; i++) begin
      if (!iv) begin iv = 1; ia = 32'h200; end
      if (!dv) begin dv = 1; da = 32'h3000; end
      step();
    end
    chk("fill_before_reset", outq.size(), MO);
    @(negedge clk);
    if_req_valid = 1; d_req_valid = 1; mem_resp_valid = 1; mem_req_ready = 1;
    #2 rst_n = 0;
    #1;
    chk("async_mem_req_valid", {31'b0, mem_req_valid}, 0);
    chk("async_if_resp_valid", {31'b0, if_resp_valid}, 0);
    chk("async_d_resp_valid", {31'b0, d_resp_valid}, 0);
    mem_resp_valid = 0; if_req_valid = 0; d_req_valid = 0;
    outq.delete(); exp_mem.delete(); exp_if.delete(); exp_d.delete(); exp_mrdy.delete();
    last_d = 1; lock = 0; rv_hold = 0; ni = 0; nd = 0; ndrop = 0;
    @(negedge clk) rst_n = 1;
    iv = 1; ia = 32'h400; dv = 1; da = 32'h5000; mrdy = 1; rv_en = 1; irdy = 1; drdy = 1;
    for (int i = 0; i < 3; i++) step();
    for (int i = 0; i < 800; i++) begin rand_inputs(); step(); end
    iv = 0; dv = 0; fl = 0; rv_en = 1; irdy = 1; drdy = 1;
    for (int i = 0; i < 20; i++) step();
    @(negedge clk);
    #4;
`ifdef MEM_ARB_PERF_CNT_EN
    chk("perf_if_grants", perf_if_grants, ni);
    chk("perf_d_grants", perf_d_grants, nd);
    chk("perf_dropped", perf_dropped, ndrop);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
